key_debounce4: RTL and testbench

- Four-channel push-button input conditioner for the board's active-low keys.
- Synchronises raw key lines, debounces them with a per-key stable-time counter, and produces clean levels plus one-cycle press/release event pulses.
- Input-side companion to the LED output blocks.
- Sits between the board pins and LED/mode-control logic; all outputs are synchronous to clk.

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_debounce_ch.sv | 143 ++++++++++++++
 rtl/key_debounce4.sv | 42 ++++
 tb/tb_key_debounce4.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and defaults for the key debounce block: FSM state encoding,
// 50 MHz timing constants and the counter-width helper.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_FLT = 2'd1,
        DOWN      = 2'd2,
        REL_FLT   = 2'd3
    } key_fsm_e;

    localparam int DEBOUNCE_CYCLES_50M = 1_000_000;
    localparam int LONG_CYCLES_50M     = 50_000_000;

    // Bits needed to count up to the larger of the two terminal values.
    function automatic int cnt_width(input int deb_cycles, input int long_cycles);
        int max_cycles;
        max_cycles = (deb_cycles > long_cycles) ? deb_cycles : long_cycles;
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM and registered event pulses.
// With KEY_LONG_EN defined a hold timer adds a one-shot long-press pulse.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int LONG_CYCLES     = LONG_CYCLES_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release
`ifdef KEY_LONG_EN
    ,
    output logic key_long
`endif
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    key_fsm_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_state_q, key_state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!s2_q) begin
                    state_d = PRESS_FLT;
                    cnt_d   = '0;
                end
            end
            PRESS_FLT: begin
                if (s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = DOWN;
                    press_d     = 1'b1;
                    key_state_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOWN: begin
                if (s2_q) begin
                    state_d = REL_FLT;
                    cnt_d   = '0;
                end
            end
            default: begin
                // A bounce back to pressed returns to DOWN without an event.
                if (!s2_q) begin
                    state_d = DOWN;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    release_d   = 1'b1;
                    key_state_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            s1_q        <= key_n;
            s2_q        <= s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign key_state   = key_state_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_LONG_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

    logic [CW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d;
    logic          long_q, long_d;

    // Hold time keeps running through release bounces; it restarts only on a new press.
    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (press_d) begin
            hold_d  = '0;
            fired_d = 1'b0;
        end else if (state_q == DOWN || state_q == REL_FLT) begin
            if (hold_q != LONG_LAST) begin
                hold_d = hold_q + 1'b1;
            end else if (!fired_q) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign key_long = long_q;
`endif

endmodule

// File: rtl/key_debounce4.sv
// Multi-channel push-button conditioner for active-low board keys.
// Optional long-press output enabled by defining KEY_LONG_EN.
module key_debounce4
    import key_pkg::*;
#(
    parameter int KEY_N           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int LONG_CYCLES     = LONG_CYCLES_50M
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_N-1:0] key_n,
    output logic [KEY_N-1:0] key_state,
    output logic [KEY_N-1:0] key_press,
    output logic [KEY_N-1:0] key_release
`ifdef KEY_LONG_EN
    ,
    output logic [KEY_N-1:0] key_long
`endif
);

    generate
        for (genvar gi = 0; gi < KEY_N; gi++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LONG_CYCLES     (LONG_CYCLES)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .key_n       (key_n[gi]),
                .key_state   (key_state[gi]),
                .key_press   (key_press[gi]),
                .key_release (key_release[gi])
`ifdef KEY_LONG_EN
                ,
                .key_long    (key_long[gi])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce4.sv
// Bench for key_debounce4: directed scenarios plus random bouncing keys, all checked
// every cycle against a run-length reference model (long-press checks with KEY_LONG_EN).
module tb_key_debounce4;

    localparam int DEB  = 8;
    localparam int LONG = 40;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'b0000;
    logic [3:0] key_state, key_press, key_release;
`ifdef KEY_LONG_EN
    logic [3:0] key_long;
`endif

    key_debounce4 #(
        .KEY_N           (4),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release)
`ifdef KEY_LONG_EN
        ,
        .key_long    (key_long)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Reference model: a key's accepted level flips once DEB+1 consecutive
    // synchronised samples (raw input two clocks earlier) disagree with it.
    int         edge_cnt = 0;
    logic [3:0] dly0, dly1, d_raw;
    logic [3:0] m_state, m_press, m_release;
    int         run [4];
    int         press_cnt [4], release_cnt [4], press_edge [4], release_edge [4];
`ifdef KEY_LONG_EN
    logic [3:0] m_long;
    int         due [4];
    bit         armed [4];
    int         long_cnt [4], long_edge [4];
`endif

    initial begin
        for (int k = 0; k < 4; k++) begin
            press_cnt[k] = 0; release_cnt[k] = 0; press_edge[k] = 0; release_edge[k] = 0;
`ifdef KEY_LONG_EN
            long_cnt[k] = 0; long_edge[k] = 0;
`endif
        end
    end

    always @(posedge clk) begin
        edge_cnt++;
        m_press   = '0;
        m_release = '0;
`ifdef KEY_LONG_EN
        m_long    = '0;
`endif
        if (!rst_n) begin
            dly0    = 4'b1111;
            dly1    = 4'b1111;
            m_state = '0;
            for (int k = 0; k < 4; k++) begin
                run[k] = 0;
`ifdef KEY_LONG_EN
                armed[k] = 1'b0;
                due[k]   = 0;
`endif
            end
        end else begin
            d_raw = dly1;
            dly1  = dly0;
            dly0  = key_n;
            for (int k = 0; k < 4; k++) begin
`ifdef KEY_LONG_EN
                if (armed[k] && edge_cnt == due[k]) begin
                    m_long[k] = 1'b1;
                    armed[k]  = 1'b0;
                end
`endif
                if (!d_raw[k] != m_state[k]) begin
                    run[k]++;
                    if (run[k] == DEB + 1) begin
                        run[k]     = 0;
                        m_state[k] = !d_raw[k];
                        if (m_state[k]) begin
                            m_press[k] = 1'b1;
`ifdef KEY_LONG_EN
                            due[k]   = edge_cnt + LONG;
                            armed[k] = 1'b1;
`endif
                        end else begin
                            m_release[k] = 1'b1;
`ifdef KEY_LONG_EN
                            armed[k] = 1'b0;
`endif
                        end
                    end
                end else begin
                    run[k] = 0;
                end
            end
        end
        #1;
        check_val("key_state", {28'd0, key_state}, {28'd0, m_state});
        check_val("key_press", {28'd0, key_press}, {28'd0, m_press});
        check_val("key_release", {28'd0, key_release}, {28'd0, m_release});
`ifdef KEY_LONG_EN
        check_val("key_long", {28'd0, key_long}, {28'd0, m_long});
`endif
        for (int k = 0; k < 4; k++) begin
            if (key_press[k] === 1'b1) begin press_cnt[k]++; press_edge[k] = edge_cnt; end
            if (key_release[k] === 1'b1) begin release_cnt[k]++; release_edge[k] = edge_cnt; end
`ifdef KEY_LONG_EN
            if (key_long[k] === 1'b1) begin long_cnt[k]++; long_edge[k] = edge_cnt; end
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int a0, a1, snap, rem [4];

    initial begin
        // Reset held with all keys pressed.
        tick(4);
        check_val("reset_outputs", {20'd0, key_state, key_press, key_release}, 32'd0);
        rst_n = 1'b1;
        a0 = edge_cnt + 1;
        tick(14);
        for (int k = 0; k < 4; k++) begin
            check_val("reset_release_press_lat", press_edge[k] - a0, DEB + 2);
            check_val("reset_release_press_cnt", press_cnt[k], 1);
        end
        $display("reset: 4 keys held through reset, press at edge %0d", press_edge[0]);
        key_n = 4'b1111;
        tick(15);

        // Clean press and release on key 0.
        key_n[0] = 1'b0;
        a0 = edge_cnt + 1;
        tick(30);
        check_val("clean_press_lat", press_edge[0] - a0, DEB + 2);
        check_val("clean_state_high", {31'd0, key_state[0]}, 1);
        key_n[0] = 1'b1;
        a0 = edge_cnt + 1;
        tick(15);
        check_val("clean_release_lat", release_edge[0] - a0, DEB + 2);
        check_val("clean_state_low", {31'd0, key_state[0]}, 0);
        $display("clean: key0 press edge %0d release edge %0d", press_edge[0], release_edge[0]);

        // Bounce rejection on key 1.
        snap = press_cnt[1];
        repeat (6) begin
            key_n[1] = 1'b0; tick(5);
            key_n[1] = 1'b1; tick(5);
        end
        check_val("bounce_no_press", press_cnt[1] - snap, 0);
        key_n[1] = 1'b0;
        tick(12);
        check_val("bounce_then_stable", press_cnt[1] - snap, 1);
        key_n[1] = 1'b1;
        tick(15);
        $display("bounce: key1 presses after bounce burst + stable low = %0d", press_cnt[1] - snap);

        // Independence: key 2 then key 3 three clocks later.
        snap = press_cnt[0] + press_cnt[1];
        key_n[2] = 1'b0;
        tick(3);
        key_n[3] = 1'b0;
        tick(15);
        check_val("indep_spacing", press_edge[3] - press_edge[2], 3);
        check_val("indep_others_quiet", press_cnt[0] + press_cnt[1] - snap, 0);
        key_n[3:2] = 2'b11;
        tick(15);
        $display("indep: key2 press edge %0d key3 press edge %0d", press_edge[2], press_edge[3]);

        // Reset while key 0 is held.
        key_n[0] = 1'b0;
        tick(15);
        check_val("midrst_state_before", {31'd0, key_state[0]}, 1);
        snap = release_cnt[0];
        rst_n = 1'b0;
        #1;
        check_val("midrst_state_now", {28'd0, key_state}, 0);
        tick(3);
        rst_n = 1'b1;
        a1 = edge_cnt + 1;
        tick(15);
        check_val("midrst_no_release", release_cnt[0] - snap, 0);
        check_val("midrst_repress_lat", press_edge[0] - a1, DEB + 2);
        key_n[0] = 1'b1;
        tick(15);
        $display("midrst: key0 re-accepted at edge %0d", press_edge[0]);

`ifdef KEY_LONG_EN
        // Long press with a short release glitch part-way through.
        snap = long_cnt[0];
        key_n[0] = 1'b0;
        tick(30);
        key_n[0] = 1'b1;
        tick(3);
        key_n[0] = 1'b0;
        tick(80);
        check_val("long_once", long_cnt[0] - snap, 1);
        check_val("long_timing", long_edge[0] - press_edge[0], LONG);
        key_n[0] = 1'b1;
        tick(15);
        key_n[0] = 1'b0;
        tick(60);
        check_val("long_rearm", long_cnt[0] - snap, 2);
        key_n[0] = 1'b1;
        tick(15);
        $display("long: key0 long pulses = %0d", long_cnt[0] - snap);
`endif

        // Random bouncing keys with occasional resets.
        key_n = 4'b1111;
        for (int k = 0; k < 4; k++) rem[k] = $urandom_range(1, 14);
        repeat (2500) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 4; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    key_n[k] = ~key_n[k];
                    rem[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 60) : $urandom_range(1, 14);
                end
            end
        end
        rst_n = 1'b1;
        key_n = 4'b1111;
        tick(15);
        $display("random: presses per key %0d %0d %0d %0d", press_cnt[0], press_cnt[1], press_cnt[2], press_cnt[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
